core_mem_arbiter: RTL and testbench

- Shares one single-port memory bus between the instruction fetch stage and the load/store accesses issued by the decode stage.
- Sequences one bus transaction at a time. Data accesses have priority over fetch.
- Performs byte-lane steering, sign/zero extension and misalignment checks.
- Raises access-fault/misaligned exceptions with RISC-V cause codes.
- Drives a pipeline stall while a data access is outstanding.

---
 rtl/core_mem_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_arbiter
// Description : Single-port memory bus arbiter for fetch and load/store with
//               lane steering, load extension, misalignment and timeout faults.
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        ls_load,
    input  logic        ls_store,
    input  logic [31:0] ls_load_addr,
    input  logic [31:0] ls_store_addr,
    input  logic [31:0] ls_store_data,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic        pipeline_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        exception,
    output logic [3:0]  exception_cause
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_BUS_DATA  = 2'd1;
    localparam logic [1:0]  c_BUS_FETCH = 2'd2;
    localparam logic [1:0]  c_RESP      = 2'd3;
    localparam logic [15:0] c_TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [15:0] r_cnt;
    logic        r_is_fetch;
    logic        r_is_store;
    logic        r_exc;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic [1:0]  r_size;

    logic        w_data_req;
    logic [31:0] w_daddr;
    logic        w_dmis;
    logic        w_fmis;
    logic [3:0]  w_be;
    logic        w_timeout;
    logic [31:0] w_shift;
    logic [31:0] w_load;
    logic        w_sext;

    // Load wins over a simultaneous store; the store simply waits.
    assign w_data_req = ls_load | ls_store;
    assign w_daddr    = ls_load ? ls_load_addr : ls_store_addr;
    assign w_fmis     = |if_addr[1:0];
    assign w_timeout  = ~bus_ready & (r_cnt == c_TO_LAST);

    always_comb begin
        case (ls_size)
            2'd0: begin
                w_dmis = 1'b0;
                w_be   = 4'b0001 << w_daddr[1:0];
            end
            2'd1: begin
                w_dmis = w_daddr[0];
                w_be   = 4'b0011 << w_daddr[1:0];
            end
            default: begin
                w_dmis = |w_daddr[1:0];
                w_be   = 4'b1111;
            end
        endcase
    end

    assign w_shift = bus_rdata >> {r_off, 3'b000};
    assign w_sext  = ~r_unsigned;

    always_comb begin
        case (r_size)
            2'd0:    w_load = {{24{w_sext & w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_load = {{16{w_sext & w_shift[15]}}, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_data_req) begin
                    w_next = w_dmis ? c_RESP : c_BUS_DATA;
                end else if (if_req) begin
                    w_next = w_fmis ? c_RESP : c_BUS_FETCH;
                end
            end
            c_BUS_DATA, c_BUS_FETCH: begin
                if (bus_ready || w_timeout) begin
                    w_next = c_RESP;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        bus_req   = (r_state == c_BUS_DATA) || (r_state == c_BUS_FETCH);
        bus_we    = (r_state == c_BUS_DATA) && r_is_store;
        if_done   = (r_state == c_RESP) && r_is_fetch;
        ls_done   = (r_state == c_RESP) && !r_is_fetch;
        exception = (r_state == c_RESP) && r_exc;
    end

    assign pipeline_stall = w_data_req & ~ls_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt           <= 16'd0;
            r_is_fetch      <= 1'b0;
            r_is_store      <= 1'b0;
            r_exc           <= 1'b0;
            r_unsigned      <= 1'b0;
            r_off           <= 2'd0;
            r_size          <= 2'd0;
            bus_addr        <= 32'd0;
            bus_wdata       <= 32'd0;
            bus_be          <= 4'd0;
            if_rdata        <= 32'd0;
            ls_rdata        <= 32'd0;
            exception_cause <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= 16'd0;
                    if (w_data_req) begin
                        r_is_fetch <= 1'b0;
                        r_is_store <= ~ls_load;
                        r_exc      <= w_dmis;
                        r_unsigned <= ls_unsigned;
                        r_off      <= w_daddr[1:0];
                        r_size     <= ls_size;
                        if (w_dmis) begin
                            ls_rdata        <= 32'd0;
                            exception_cause <= ls_load ? 4'd4 : 4'd6;
                        end else begin
                            bus_addr  <= {w_daddr[31:2], 2'b00};
                            bus_be    <= w_be;
                            bus_wdata <= ls_load ? 32'd0 : (ls_store_data << {w_daddr[1:0], 3'b000});
                        end
                    end else if (if_req) begin
                        r_is_fetch <= 1'b1;
                        r_is_store <= 1'b0;
                        r_exc      <= w_fmis;
                        if (w_fmis) begin
                            if_rdata        <= 32'd0;
                            exception_cause <= 4'd0;
                        end else begin
                            bus_addr  <= {if_addr[31:2], 2'b00};
                            bus_be    <= 4'b1111;
                            bus_wdata <= 32'd0;
                        end
                    end
                end
                c_BUS_DATA, c_BUS_FETCH: begin
                    if (bus_ready) begin
                        if (r_is_fetch) begin
                            if_rdata <= bus_rdata;
                        end else begin
                            ls_rdata <= r_is_store ? 32'd0 : w_load;
                        end
                    end else if (w_timeout) begin
                        r_exc <= 1'b1;
                        if (r_is_fetch) begin
                            if_rdata        <= 32'd0;
                            exception_cause <= 4'd1;
                        end else begin
                            ls_rdata        <= 32'd0;
                            exception_cause <= r_is_store ? 4'd7 : 4'd5;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mem_arbiter
// Description : Randomized scoreboard bench for core_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_core_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        ls_load, ls_store;
    logic [31:0] ls_load_addr, ls_store_addr, ls_store_data;
    logic [1:0]  ls_size;
    logic        ls_unsigned;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        pipeline_stall;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        exception;
    logic [3:0]  exception_cause;

    core_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .ls_load(ls_load), .ls_store(ls_store), .ls_load_addr(ls_load_addr),
        .ls_store_addr(ls_store_addr), .ls_store_data(ls_store_data),
        .ls_size(ls_size), .ls_unsigned(ls_unsigned), .ls_done(ls_done),
        .ls_rdata(ls_rdata), .pipeline_stall(pipeline_stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .exception(exception), .exception_cause(exception_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fetch;
        logic [31:0] rdata;
        bit          exc;
        logic [3:0]  cause;
        bit          has_bus;
        logic [31:0] baddr;
        logic [3:0]  be;
        bit          we;
        logic [31:0] wdata;
        int          nreq;
        int          lat;
        int          issue;
    } exp_t;

    typedef struct {
        int          delay;
        logic [31:0] rdata;
    } sl_t;

    exp_t exp_q[$];
    sl_t  sl_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference: expected response of one access from the architectural rules.
    function automatic exp_t model(input int kind, input logic [31:0] addr, input logic [1:0] size,
                                   input bit uns, input logic [31:0] sdata, input int delay,
                                   input logic [31:0] rd);
        exp_t        e;
        int          nb;
        int          off;
        logic [31:0] mask;
        logic [31:0] v;
        nb         = (kind == 2) ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off        = int'(addr % 4);
        e.is_fetch = (kind == 2);
        e.has_bus  = (addr % nb) == 0;
        e.baddr    = addr - 32'(off);
        e.be       = 4'(((1 << nb) - 1) << off);
        e.we       = (kind == 1);
        e.wdata    = (kind == 1) ? (sdata << (8 * off)) : 32'd0;
        e.issue    = 0;
        if (!e.has_bus) begin
            e.exc = 1; e.cause = (kind == 0) ? 4'd4 : (kind == 1) ? 4'd6 : 4'd0;
            e.rdata = 0; e.nreq = 0; e.lat = 1;
        end else if (delay >= TO) begin
            e.exc = 1; e.cause = (kind == 0) ? 4'd5 : (kind == 1) ? 4'd7 : 4'd1;
            e.rdata = 0; e.nreq = TO; e.lat = TO + 1;
        end else begin
            e.exc = 0; e.cause = 0; e.nreq = delay + 1; e.lat = delay + 2;
            if (kind == 2) e.rdata = rd;
            else if (kind == 1) e.rdata = 0;
            else begin
                mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
                v = (rd >> (8 * off)) & mask;
                if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // Bus slave: answers each new bus_req after the delay queued for it.
    initial begin
        sl_t s_cur;
        int  s_cnt;
        bit  s_act;
        s_act = 0; s_cnt = 0; s_cur.delay = 1000; s_cur.rdata = 0;
        bus_ready = 0; bus_rdata = 0;
        forever begin
            @(negedge clk);
            bus_ready = 0;
            bus_rdata = $urandom();
            if (!bus_req || rst) begin
                s_act = 0;
            end else begin
                if (!s_act) begin
                    if (sl_q.size() == 0) begin
                        chk("unexpected_bus_req", 32'd1, 32'd0);
                        s_cur.delay = 1000;
                    end else begin
                        s_cur = sl_q.pop_front();
                    end
                    s_act = 1; s_cnt = 0;
                end
                if (s_cnt == s_cur.delay) begin
                    bus_ready = 1;
                    bus_rdata = s_cur.rdata;
                end
                s_cnt++;
            end
        end
    end

    // Monitor: bus-phase and completion checks against the scoreboard head.
    initial begin
        exp_t e;
        int   nreq;
        nreq = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nreq = 0;
            end else begin
                chk("pipeline_stall", 32'(pipeline_stall), 32'((ls_load | ls_store) & ~ls_done));
                if (bus_req) begin
                    nreq++;
                    if (exp_q.size() == 0) begin
                        chk("bus_req_without_request", 32'd1, 32'd0);
                    end else begin
                        chk("bus_access_expected", 32'd1, 32'(exp_q[0].has_bus));
                        chk("bus_addr", bus_addr, exp_q[0].baddr);
                        chk("bus_be", 32'(bus_be), 32'(exp_q[0].be));
                        chk("bus_we", 32'(bus_we), 32'(exp_q[0].we));
                        chk("bus_wdata", bus_wdata, exp_q[0].wdata);
                    end
                end
                if (if_done && ls_done) chk("both_done", 32'd1, 32'd0);
                if (if_done || ls_done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_without_request", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_kind_is_fetch", 32'(if_done), 32'(e.is_fetch));
                        chk("rdata", e.is_fetch ? if_rdata : ls_rdata, e.rdata);
                        chk("exception", 32'(exception), 32'(e.exc));
                        if (e.exc) chk("exception_cause", 32'(exception_cause), 32'(e.cause));
                        chk("bus_req_cycles", 32'(nreq), 32'(e.nreq));
                        if (e.lat >= 0) chk("latency", 32'(cyc - e.issue), 32'(e.lat));
                    end
                    nreq = 0;
                end else if (exception) begin
                    chk("exception_without_done", 32'd1, 32'd0);
                end
            end
        end
    end

    task automatic wait_done(input bit fetch);
        bit got;
        got = 0;
        for (int n = 0; n < 80 && !got; n++) begin
            @(negedge clk);
            got = fetch ? if_done : ls_done;
        end
        if (!got) chk(fetch ? "if_done_timeout" : "ls_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_bus_req();
        bit got;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = bus_req;
        end
        if (!got) chk("bus_req_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive(input int kind, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] sdata, input bit both);
        if (kind == 2) begin
            if_req = 1; if_addr = addr;
        end else if (kind == 1) begin
            ls_store = 1; ls_store_addr = addr; ls_store_data = sdata; ls_size = size;
        end else begin
            ls_load = 1; ls_load_addr = addr; ls_size = size; ls_unsigned = uns;
            if (both) begin
                ls_store = 1; ls_store_addr = $urandom(); ls_store_data = $urandom();
            end
        end
    endtask

    task automatic issue(input int kind, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] sdata, input int delay,
                         input logic [31:0] rd, input bit both);
        exp_t e;
        sl_t  s;
        @(posedge clk); #1;
        e = model(kind, addr, size, uns, sdata, delay, rd);
        e.issue = cyc;
        if (e.has_bus) begin
            s.delay = delay; s.rdata = rd;
            sl_q.push_back(s);
        end
        exp_q.push_back(e);
        drive(kind, addr, size, uns, sdata, both);
        wait_done(kind == 2);
        @(posedge clk); #1;
        if_req = 0; ls_load = 0; ls_store = 0;
    endtask

    task automatic check_reset_values();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_ls_done", 32'(ls_done), 32'd0);
        chk("rst_exception", 32'(exception), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        chk("rst_exception_cause", 32'(exception_cause), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        exp_t e1, e2;
        sl_t  s;
        rst = 1; if_req = 0; if_addr = 0; ls_load = 0; ls_store = 0;
        ls_load_addr = 0; ls_store_addr = 0; ls_store_data = 0; ls_size = 0; ls_unsigned = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        @(posedge clk); #1;
        rst = 0;

        // Directed accesses
        issue(0, 32'h0000_0100, 2'd2, 0, 0, 2, 32'hDEAD_BEEF, 0);
        issue(0, 32'h0000_0203, 2'd0, 0, 0, 1, 32'h8011_2233, 0);
        issue(0, 32'h0000_0203, 2'd0, 1, 0, 0, 32'h8011_2233, 0);
        issue(1, 32'h0000_0302, 2'd1, 0, 32'h0000_ABCD, 1, 0, 0);
        issue(0, 32'h0000_0302, 2'd2, 0, 0, 0, 0, 0);
        issue(0, 32'h0000_0101, 2'd1, 0, 0, 0, 0, 0);
        issue(1, 32'h0000_0103, 2'd3, 0, 32'h1, 0, 0, 0);
        issue(2, 32'h0000_0102, 2'd0, 0, 0, 0, 0, 0);
        issue(0, 32'h0000_0402, 2'd1, 0, 0, 0, 32'h9ABC_1234, 1);
        issue(1, 32'h0000_0040, 2'd2, 0, 32'h5555_AAAA, 9, 0, 0);
        issue(0, 32'h0000_0044, 2'd2, 0, 0, 9, 0, 0);
        issue(2, 32'h0000_0080, 2'd0, 0, 0, 9, 32'h1234_5678, 0);

        // Load and fetch raised together: load first, then fetch
        @(posedge clk); #1;
        e1 = model(0, 32'h0000_0500, 2'd2, 0, 0, 1, 32'h1111_2222);
        e1.issue = cyc;
        e2 = model(2, 32'h0000_0600, 2'd0, 0, 0, 0, 32'h3333_4444);
        e2.lat = -1;
        s.delay = 1; s.rdata = 32'h1111_2222; sl_q.push_back(s);
        s.delay = 0; s.rdata = 32'h3333_4444; sl_q.push_back(s);
        exp_q.push_back(e1); exp_q.push_back(e2);
        drive(0, 32'h0000_0500, 2'd2, 0, 0, 0);
        drive(2, 32'h0000_0600, 2'd0, 0, 0, 0);
        wait_done(0);
        @(posedge clk); #1; ls_load = 0;
        wait_done(1);
        @(posedge clk); #1; if_req = 0;

        // Load raised while a fetch is on the bus must wait for it
        @(posedge clk); #1;
        e1 = model(2, 32'h0000_0700, 2'd0, 0, 0, 3, 32'hCAFE_F00D);
        e1.issue = cyc;
        s.delay = 3; s.rdata = 32'hCAFE_F00D; sl_q.push_back(s);
        exp_q.push_back(e1);
        drive(2, 32'h0000_0700, 2'd0, 0, 0, 0);
        wait_bus_req();
        e2 = model(0, 32'h0000_0806, 2'd1, 0, 0, 0, 32'h8001_0000);
        e2.lat = -1;
        s.delay = 0; s.rdata = 32'h8001_0000; sl_q.push_back(s);
        exp_q.push_back(e2);
        drive(0, 32'h0000_0806, 2'd1, 0, 0, 0);
        #1 chk("stall_while_fetch_busy", 32'(pipeline_stall), 32'd1);
        wait_done(1);
        @(posedge clk); #1; if_req = 0;
        wait_done(0);
        @(posedge clk); #1; ls_load = 0;

        // Reset during a data bus access abandons it
        @(posedge clk); #1;
        e1 = model(1, 32'h0000_0900, 2'd2, 0, 32'h1234, 9, 0);
        e1.issue = cyc;
        s.delay = 9; s.rdata = 0; sl_q.push_back(s);
        exp_q.push_back(e1);
        drive(1, 32'h0000_0900, 2'd2, 0, 32'h1234, 0);
        wait_bus_req();
        @(posedge clk); #1;
        rst = 1; ls_store = 0;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check_reset_values();
        repeat (4) @(negedge clk);
        chk("abandoned_entry_pending", 32'(exp_q.size()), 32'd1);
        exp_q.delete();

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int          kind;
            logic [31:0] addr;
            int          delay;
            kind = int'($urandom_range(0, 2));
            addr = $urandom();
            if (kind == 2 && $urandom_range(0, 9) != 0) addr[1:0] = 2'b00;
            delay = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : 9;
            issue(kind, addr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom(),
                  delay, $urandom(), (kind == 0) && ($urandom_range(0, 1) == 1));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
